// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encoding
//
// Holds the data width, the default bit period, and the transmitter FSM state
// type used by uart_tx_buf. The PARITY state exists only when
// UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_W           = 8;
    localparam int UART_CLKS_PER_BIT_DEF = 868;   // 115200 baud at 100 MHz

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - small byte FIFO feeding the UART transmitter
//
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   push, wr_data  write request and byte; ignored when full unless popping
//   pop            read request; rd_data is the head byte (valid while !empty)
//   full, empty    occupancy flags
//   count          current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_byte_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop & ~empty;
    // A pop on the same edge frees the head slot, so a push while full is
    // accepted; the head was already read out combinationally before the edge.
    assign do_push = push & (~full | do_pop);

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter with edge-detected start
//
// Ports:
//   clk, rstn  clock, synchronous active-low reset
//   start_i    level request; each rising edge queues data_i once
//   data_i     byte to send, captured on the start_i rising edge
//   tx_o       serial line, idle high, 8 data bits LSB first
//   busy_o     frame on the line or bytes still queued
//   full_o     FIFO holds FIFO_DEPTH bytes
//   drop_o     one-cycle pulse after a byte was discarded on overflow
// Build option: UART_TX_PARITY_EN adds an even parity bit (8E1 frame).
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start_i,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   full_o,
    output logic                   drop_o
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e            state;
    logic                   start_prev;
    logic                   push;
    logic                   pop;
    logic                   drop;
    logic                   bit_end;
    logic [TW-1:0]          timer;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic [UART_DATA_W-1:0] fifo_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
`ifdef UART_TX_PARITY_EN
    logic                   par_bit;
`endif

    // The upstream holds start_i high for a long time; only its rising edge
    // counts as a request.
    assign push    = start_i & ~start_prev;
    assign pop     = (state == ST_IDLE) & ~fifo_empty;
    assign drop    = push & fifo_full & ~pop;
    assign bit_end = (timer == TW'(CLKS_PER_BIT - 1));

    uart_byte_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .wr_data (data_i),
        .pop     (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            start_prev <= 1'b0;
            drop_o     <= 1'b0;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            start_prev <= start_i;
            drop_o     <= drop;

            if (state == ST_IDLE || bit_end) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shreg   <= fifo_data;
                        bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                        par_bit <= ^fifo_data;
`endif
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shreg   <= {1'b0, shreg[UART_DATA_W-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // Returning to IDLE guarantees at least one idle cycle
                    // before the next frame is popped.
                    if (bit_end) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_o = 1'b1;
        case (state)
            ST_START:  tx_o = 1'b0;
            ST_DATA:   tx_o = shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_o = par_bit;
`endif
            default:   tx_o = 1'b1;
        endcase
    end

    assign busy_o = (state != ST_IDLE) | (fifo_count != '0);
    assign full_o = fifo_full;

endmodule
